intersection_controller: RTL
============================

// Module: intersection_controller
// PURPOSE
//  Central phase sequencer for a two-way intersection. It drives the NS and EW
//  4-bit lamp buses from one shared FSM, so conflicting greens cannot occur.
//  Handles all-red clearance, emergency pre-emption and optional EW demand sensing.
//  Lamp buses go straight to the lamp drivers and replace free-running per-direction
//  light blocks. Lamp encoding {left,green,yellow,red}:
//  LEFT=4'b1001, GREEN=4'b0100, YELLOW=4'b0010, RED=4'b0001.
// PARAMETERS
//  T_LEFT    5   cycles in protected-left phase (>=1)
//  T_GREEN   10  cycles in green phase (>=1)
//  T_YELLOW  3   cycles in yellow phase, normal and emergency (>=1)
//  T_ALLRED  2   cycles of all-red clearance (>=1)
//  CW        5   phase counter width; every T_* must be <= 2**CW
// PORTS
//  clk        in   1  rising-edge clock, one tick per timing unit
//  rst        in   1  asynchronous, active-high reset
//  emergency  in   1  level request, synchronous to clk; high = pre-empt to all-red
//  ew_car     in   1  EW vehicle-present pulse/level (used only with EW_SENSE_EN)
//  ns_out     out  4  NS lamp bus
//  ew_out     out  4  EW lamp bus
//  phase      out  4  current FSM state code (debug/verification)
//  emg_active out  1  high in EMG_YEL, EMG_HOLD, EMG_CLR
// BEHAVIOUR
//  - State codes: 0 NS_LEFT, 1 NS_GRN, 2 NS_YEL, 3 AR1, 4 EW_LEFT, 5 EW_GRN, 6 EW_YEL,
//    7 AR2, 8 EMG_YEL, 9 EMG_HOLD, 10 EMG_CLR.
//  - Reset (async): state=AR2, cnt=0, ns_out=ew_out=RED, phase=7, emg_active=0,
//    resume_ew=0, ew_req=0.
//  - Outputs are a decode of the registered state only; no combinational input->output path.
//  - Timed states hold exactly T cycles. cnt counts 0..T-1. At cnt==T-1 the FSM advances
//    and cnt<=0. Every state change clears cnt.
//  - Normal ring: NS_LEFT->NS_GRN->NS_YEL->AR1->EW_LEFT->EW_GRN->EW_YEL->AR2->NS_LEFT.
//    Full cycle = 2*(T_LEFT+T_GREEN+T_YELLOW+T_ALLRED) = 40 cycles at defaults.
//  - Lamps: *_LEFT gives that direction LEFT, *_GRN gives GREEN, *_YEL gives YELLOW;
//    the other direction is RED. AR1, AR2, EMG_HOLD and EMG_CLR give both RED.
//    EMG_YEL gives YELLOW on the interrupted direction, RED on the other.
//  - Emergency is sampled each rising edge:
//    * In NS_LEFT/NS_GRN: go to EMG_YEL next cycle with NS yellow, resume_ew<=1.
//      In EW_LEFT/EW_GRN: same with EW yellow, resume_ew<=0.
//    * In NS_YEL/EW_YEL: the current yellow runs to completion, then EMG_HOLD.
//      resume_ew is set as above.
//    * In AR1/AR2: go to EMG_HOLD next cycle. resume_ew<=1 from AR1, 0 from AR2.
//    * EMG_YEL lasts T_YELLOW cycles, then EMG_HOLD. It does not abort if emergency drops.
//    * EMG_HOLD is untimed. It stays while emergency=1. On emergency=0 -> EMG_CLR.
//    * EMG_CLR lasts T_ALLRED cycles, then EW_LEFT if resume_ew else NS_LEFT.
//      If emergency rises again during EMG_CLR -> EMG_HOLD immediately.
//  - Invariant: ns_out and ew_out are never both non-RED in any cycle.
//  - Reset mid-operation (any state, incl. emergency) forces RED/RED at once.
//    After release, sequencing restarts with AR2.
// CONFIGURATION
//  EW_SENSE_EN defined:
//    - ew_req is a sticky flag, set by any cycle with ew_car=1.
//    - ew_req is cleared on entry to EW_LEFT.
//    - At the end of AR1, if ew_req=0 the FSM goes to NS_LEFT (EW phases skipped)
//      instead of EW_LEFT.
//    - Emergency resume always honours resume_ew, regardless of ew_req.
//  EW_SENSE_EN undefined: ew_car is ignored, ew_req is held 0, and the ring is always full.
// TESTING
//  1 Reset, release, run 45 cycles -> RED/RED for 2 cycles; NS LEFT 5, GREEN 10,
//    YELLOW 3, all-red 2; EW repeats the pattern; period 40.
//  2 emergency=1 for 8 cycles starting at NS_GRN cnt=4 -> NS YELLOW 3, then RED/RED
//    with emg_active=1 until drop; EMG_CLR 2; then EW_LEFT.
//  3 emergency pulse 1 cycle in AR2 -> EMG_HOLD 1 cycle, EMG_CLR 2, then NS_LEFT.
//    No yellow is shown.
//  4 emergency asserted in EW_YEL cnt=0 -> EW yellow completes its full 3 cycles,
//    then EMG_HOLD.
//  5 rst asserted mid EW_GRN -> outputs RED/RED in the same cycle, phase=7;
//    after release the test-1 timing repeats.
//  6 EW_SENSE_EN, ew_car=0 throughout -> NS-only loop of 20 cycles, ew_out always RED.
//    One ew_car pulse -> next AR1 leads to EW_LEFT.
//  Every scenario also asserts the invariant that ns_out and ew_out are never both non-RED.

Source files
------------

// File: rtl/intersection_controller.sv
// intersection_controller
// Phase sequencer for a two-way intersection. A single FSM owns both lamp
// buses, so NS and EW can never be given conflicting right-of-way.
// Handles all-red clearance, emergency pre-emption and resume.
// Lamp encoding {left,green,yellow,red}.
// Optional feature: define EW_SENSE_EN to skip the EW phases when no EW
// vehicle has been seen since the last EW service.
module intersection_controller #(
  parameter int unsigned T_LEFT   = 5,
  parameter int unsigned T_GREEN  = 10,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 2,
  parameter int unsigned CW       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emergency,
  input  logic       ew_car,
  output logic [3:0] ns_out,
  output logic [3:0] ew_out,
  output logic [3:0] phase,
  output logic       emg_active
);

  localparam logic [3:0] LAMP_LEFT   = 4'b1001;
  localparam logic [3:0] LAMP_GREEN  = 4'b0100;
  localparam logic [3:0] LAMP_YELLOW = 4'b0010;
  localparam logic [3:0] LAMP_RED    = 4'b0001;

  // Terminal counts: a state with duration T leaves when cnt reaches T-1.
  localparam logic [CW-1:0] LEFT_LAST   = CW'(T_LEFT - 1);
  localparam logic [CW-1:0] GREEN_LAST  = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] ALLRED_LAST = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [3:0] {
    S_NS_LEFT  = 4'd0,
    S_NS_GRN   = 4'd1,
    S_NS_YEL   = 4'd2,
    S_AR1      = 4'd3,
    S_EW_LEFT  = 4'd4,
    S_EW_GRN   = 4'd5,
    S_EW_YEL   = 4'd6,
    S_AR2      = 4'd7,
    S_EMG_YEL  = 4'd8,
    S_EMG_HOLD = 4'd9,
    S_EMG_CLR  = 4'd10
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // resume_ew: after the emergency, restart at EW_LEFT (1) or NS_LEFT (0).
  // In EMG_YEL it also tells which direction was interrupted (1 = NS).
  logic          resume_ew_q, resume_ew_d;
  // emg_pend: emergency seen during a yellow that must still complete.
  logic          emg_pend_q, emg_pend_d;
  logic          ew_req_q, ew_req_d;
  logic          done_s;
  logic          yel_pend_s;

  logic [3:0]    ns_out_q, ns_out_d;
  logic [3:0]    ew_out_q, ew_out_d;
  logic [3:0]    phase_q, phase_d;
  logic          emg_active_q, emg_active_d;

  // True when the current timed state has used up its duration.
  function automatic logic timer_done(input state_t s, input logic [CW-1:0] c);
    logic d;
    case (s)
      S_NS_LEFT, S_EW_LEFT:           d = (c == LEFT_LAST);
      S_NS_GRN, S_EW_GRN:             d = (c == GREEN_LAST);
      S_NS_YEL, S_EW_YEL, S_EMG_YEL:  d = (c == YELLOW_LAST);
      S_AR1, S_AR2, S_EMG_CLR:        d = (c == ALLRED_LAST);
      default:                        d = 1'b0;
    endcase
    return d;
  endfunction

  // NS lamp decode for a given state.
  function automatic logic [3:0] ns_lamp(input state_t s, input logic ns_interrupted);
    logic [3:0] l;
    case (s)
      S_NS_LEFT: l = LAMP_LEFT;
      S_NS_GRN:  l = LAMP_GREEN;
      S_NS_YEL:  l = LAMP_YELLOW;
      S_EMG_YEL: l = ns_interrupted ? LAMP_YELLOW : LAMP_RED;
      default:   l = LAMP_RED;
    endcase
    return l;
  endfunction

  // EW lamp decode for a given state.
  function automatic logic [3:0] ew_lamp(input state_t s, input logic ns_interrupted);
    logic [3:0] l;
    case (s)
      S_EW_LEFT: l = LAMP_LEFT;
      S_EW_GRN:  l = LAMP_GREEN;
      S_EW_YEL:  l = LAMP_YELLOW;
      S_EMG_YEL: l = ns_interrupted ? LAMP_RED : LAMP_YELLOW;
      default:   l = LAMP_RED;
    endcase
    return l;
  endfunction

  // Next-state, phase counter and emergency bookkeeping.
  always_comb begin
    state_d     = state_q;
    resume_ew_d = resume_ew_q;
    emg_pend_d  = 1'b0;
    done_s      = timer_done(state_q, cnt_q);
    yel_pend_s  = emg_pend_q | emergency;

    case (state_q)
      S_NS_LEFT, S_NS_GRN: begin
        if (emergency) begin
          state_d     = S_EMG_YEL;
          resume_ew_d = 1'b1;
        end else if (done_s) begin
          state_d = (state_q == S_NS_LEFT) ? S_NS_GRN : S_NS_YEL;
        end else begin
          state_d = state_q;
        end
      end
      S_EW_LEFT, S_EW_GRN: begin
        if (emergency) begin
          state_d     = S_EMG_YEL;
          resume_ew_d = 1'b0;
        end else if (done_s) begin
          state_d = (state_q == S_EW_LEFT) ? S_EW_GRN : S_EW_YEL;
        end else begin
          state_d = state_q;
        end
      end
      S_NS_YEL, S_EW_YEL: begin
        // Yellow is never cut short; a request is remembered until it ends.
        if (emergency) begin
          resume_ew_d = (state_q == S_NS_YEL);
        end else begin
          resume_ew_d = resume_ew_q;
        end
        if (done_s) begin
          if (yel_pend_s) begin
            state_d = S_EMG_HOLD;
          end else begin
            state_d = (state_q == S_NS_YEL) ? S_AR1 : S_AR2;
          end
          emg_pend_d = 1'b0;
        end else begin
          state_d    = state_q;
          emg_pend_d = yel_pend_s;
        end
      end
      S_AR1: begin
        if (emergency) begin
          state_d     = S_EMG_HOLD;
          resume_ew_d = 1'b1;
        end else if (done_s) begin
`ifdef EW_SENSE_EN
          state_d = ew_req_q ? S_EW_LEFT : S_NS_LEFT;
`else
          state_d = S_EW_LEFT;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_AR2: begin
        if (emergency) begin
          state_d     = S_EMG_HOLD;
          resume_ew_d = 1'b0;
        end else if (done_s) begin
          state_d = S_NS_LEFT;
        end else begin
          state_d = state_q;
        end
      end
      S_EMG_YEL: begin
        // Runs its full length even if the request is withdrawn.
        if (done_s) begin
          state_d = S_EMG_HOLD;
        end else begin
          state_d = state_q;
        end
      end
      S_EMG_HOLD: begin
        if (emergency) begin
          state_d = S_EMG_HOLD;
        end else begin
          state_d = S_EMG_CLR;
        end
      end
      S_EMG_CLR: begin
        if (emergency) begin
          state_d = S_EMG_HOLD;
        end else if (done_s) begin
          state_d = resume_ew_q ? S_EW_LEFT : S_NS_LEFT;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        // Unreachable code: fall back to the safe all-red start point.
        state_d     = S_AR2;
        resume_ew_d = 1'b0;
      end
    endcase

    // Every state change restarts the counter; EMG_HOLD is untimed.
    if ((state_d != state_q) || (state_q == S_EMG_HOLD)) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

`ifdef EW_SENSE_EN
  // EW demand flag: sticky on any vehicle, consumed when EW_LEFT is entered.
  always_comb begin
    ew_req_d = ew_req_q;
    if ((state_d == S_EW_LEFT) && (state_q != S_EW_LEFT)) begin
      ew_req_d = 1'b0;
    end else if (ew_car) begin
      ew_req_d = 1'b1;
    end else begin
      ew_req_d = ew_req_q;
    end
  end
`else
  logic unused_s;
  assign unused_s = ew_car | ew_req_q;

  // Without demand sensing the request flag is tied inactive.
  always_comb begin
    ew_req_d = 1'b0;
  end
`endif

  // Output decode from the next state so the registered outputs track state_q.
  always_comb begin
    ns_out_d     = ns_lamp(state_d, resume_ew_d);
    ew_out_d     = ew_lamp(state_d, resume_ew_d);
    phase_d      = state_d;
    emg_active_d = (state_d == S_EMG_YEL) || (state_d == S_EMG_HOLD) ||
                   (state_d == S_EMG_CLR);
  end

  // FSM state, phase counter and emergency/demand flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_AR2;
      cnt_q       <= CNT_ZERO;
      resume_ew_q <= 1'b0;
      emg_pend_q  <= 1'b0;
      ew_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resume_ew_q <= resume_ew_d;
      emg_pend_q  <= emg_pend_d;
      ew_req_q    <= ew_req_d;
    end
  end

  // Registered lamp and status outputs; reset forces both directions red.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ns_out_q     <= LAMP_RED;
      ew_out_q     <= LAMP_RED;
      phase_q      <= 4'd7;
      emg_active_q <= 1'b0;
    end else begin
      ns_out_q     <= ns_out_d;
      ew_out_q     <= ew_out_d;
      phase_q      <= phase_d;
      emg_active_q <= emg_active_d;
    end
  end

  assign ns_out     = ns_out_q;
  assign ew_out     = ew_out_q;
  assign phase      = phase_q;
  assign emg_active = emg_active_q;

endmodule
